cronometro_nucleo: RTL and testbench

Stopwatch timing core that consumes the 2-bit command produced by the push-button command decoder and turns it into running time. The core keeps a free-running centisecond time base, an MM:SS.CC BCD count, and a display register that can be frozen for lap readout. Its BCD digit outputs feed the seven-segment display driver.

---
 rtl/cronometro_pkg.sv | 46 ++++
 rtl/cronometro_bcd.sv | 29 ++
 rtl/cronometro_nucleo.sv | 126 ++++++++++++
 tb/tb_cronometro_nucleo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cronometro_pkg.sv
// Shared encodings for the stopwatch: button commands, FSM states and BCD types.
package cronometro_pkg;

  // Command levels, shared with the push-button command decoder.
  typedef enum logic [1:0] {
    CMD_PARA  = 2'd0,
    CMD_PAUSE = 2'd1,
    CMD_RESET = 2'd2,
    CMD_CONTA = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    PARADO    = 2'd0,
    CONTANDO  = 2'd1,
    CONGELADO = 2'd2
  } estado_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t dez;
    bcd_t uni;
  } bcd2_t;

  typedef struct packed {
    bcd2_t mm;
    bcd2_t ss;
    bcd2_t cc;
  } tempo_t;

  // Next value of a two-digit BCD counter that wraps to 00 after max.
  function automatic bcd2_t bcd2_inc(input bcd2_t v, input bcd2_t max);
    bcd2_t r;
    r = v;
    if (v == max) begin
      r = '0;
    end else if (v.uni == 4'd9) begin
      r.dez = v.dez + 4'd1;
      r.uni = 4'd0;
    end else begin
      r.uni = v.uni + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cronometro_bcd.sv
// Two-digit BCD modulo counter (00..MAX); carry is combinational so stages chain.
module bcd_mod_contador
  import cronometro_pkg::*;
#(
  parameter int MAX = 99
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  output bcd2_t val,
  output logic  carry
);

  localparam bcd2_t MAX_BCD = bcd2_t'({4'(MAX / 10), 4'(MAX % 10)});

  bcd2_t r_val;

  assign val   = r_val;
  assign carry = en && (r_val == MAX_BCD);

  // Count register: clear has priority over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_val <= '0;
    else if (clr) r_val <= '0;
    else if (en)  r_val <= bcd2_inc(r_val, MAX_BCD);
  end

endmodule

// File: rtl/cronometro_nucleo.sv
// Stopwatch core: command FSM, centisecond prescaler, MM:SS.CC count and lap display.
module cronometro_nucleo
  import cronometro_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] estado,
  output logic [7:0] cc,
  output logic [7:0] ss,
  output logic [7:0] mm,
  output logic       rodando,
  output logic       congelado,
  output logic       estouro
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  estado_e       r_state;
  estado_e       w_state_nxt;
  logic          r_run_keep;
  logic          w_keep_nxt;
  logic          w_clr;
  logic          w_freeze_entry;
  logic          w_run;
  logic          w_tick;
  logic [PW-1:0] r_presc;
  logic          r_estouro;
  tempo_t        r_disp;
  tempo_t        w_live;
  tempo_t        w_show;
  logic          w_carry_cc;
  logic          w_carry_ss;
  logic          w_carry_mm;
  cmd_e          w_cmd;

  assign w_cmd = cmd_e'(estado);

  // State register; run_keep remembers whether a freeze was entered while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PARADO;
      r_run_keep <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run_keep <= w_keep_nxt;
    end
  end

  // Next-state decode of the command level; pause is ignored while already frozen.
  always_comb begin
    w_state_nxt    = r_state;
    w_keep_nxt     = r_run_keep;
    w_clr          = 1'b0;
    w_freeze_entry = 1'b0;
    unique case (w_cmd)
      CMD_CONTA: w_state_nxt = CONTANDO;
      CMD_PARA:  w_state_nxt = PARADO;
      CMD_PAUSE: begin
        if (r_state != CONGELADO) begin
          w_state_nxt    = CONGELADO;
          w_keep_nxt     = (r_state == CONTANDO);
          w_freeze_entry = 1'b1;
        end
      end
      CMD_RESET: begin
        w_state_nxt = PARADO;
        w_keep_nxt  = 1'b0;
        w_clr       = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_run  = (r_state == CONTANDO) || ((r_state == CONGELADO) && r_run_keep);
  assign w_tick = w_run && (r_presc == PRESC_MAX);

  // Prescaler holds while stopped so a stop/start keeps the partial tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_clr)  r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else if (w_run)  r_presc <= r_presc + 1'b1;
  end

  bcd_mod_contador #(.MAX(99)) u_cc (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_tick),
    .val(w_live.cc), .carry(w_carry_cc)
  );

  bcd_mod_contador #(.MAX(59)) u_ss (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_carry_cc),
    .val(w_live.ss), .carry(w_carry_ss)
  );

  bcd_mod_contador #(.MAX(59)) u_mm (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_carry_ss),
    .val(w_live.mm), .carry(w_carry_mm)
  );

  // Overflow pulse for the cycle after the 59:59.99 wrap; a reset command suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estouro <= 1'b0;
    else        r_estouro <= w_carry_mm && !w_clr;
  end

  // Lap register captures the pre-increment count on freeze entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_disp <= '0;
    else if (w_clr)          r_disp <= '0;
    else if (w_freeze_entry) r_disp <= w_live;
  end

  assign w_show    = (r_state == CONGELADO) ? r_disp : w_live;
  assign cc        = w_show.cc;
  assign ss        = w_show.ss;
  assign mm        = w_show.mm;
  assign rodando   = w_run;
  assign congelado = (r_state == CONGELADO);
  assign estouro   = r_estouro;

endmodule

// File: tb/tb_cronometro_nucleo.sv
// Self-checking bench for cronometro_nucleo with DIV = 10 and a centisecond-integer model.
module tb_cronometro_nucleo;

  localparam int DIV   = 10;
  localparam int WRAPT = 60 * 60 * 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] estado = 2'd0;
  logic [7:0] cc, ss, mm;
  logic       rodando, congelado, estouro;

  int vectors = 0;
  int errs = 0;

  // Reference model: elapsed time as plain centiseconds, mode as flags.
  int m_t = 0, m_presc = 0, m_shown = 0;
  bit m_cnt = 0, m_frz = 0, m_keep = 0, m_wrap = 0;

  cronometro_nucleo #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado),
    .cc(cc), .ss(ss), .mm(mm),
    .rodando(rodando), .congelado(congelado), .estouro(estouro)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic void model_reset();
    m_t = 0; m_presc = 0; m_shown = 0;
    m_cnt = 0; m_frz = 0; m_keep = 0; m_wrap = 0;
  endfunction

  function automatic void model_edge(input logic [1:0] cmd);
    bit run, tick;
    run  = m_cnt || (m_frz && m_keep);
    tick = run && (m_presc == DIV - 1);
    if (cmd == 2'd2) begin
      model_reset();
      return;
    end
    m_wrap = tick && (m_t == WRAPT - 1);
    if (cmd == 2'd1 && !m_frz) m_shown = m_t;
    if (tick)     begin m_t = (m_t + 1) % WRAPT; m_presc = 0; end
    else if (run) m_presc = m_presc + 1;
    case (cmd)
      2'd3: begin m_cnt = 1; m_frz = 0; end
      2'd0: begin m_cnt = 0; m_frz = 0; end
      default: if (!m_frz) begin m_keep = m_cnt; m_frz = 1; m_cnt = 0; end
    endcase
  endfunction

  function automatic logic [26:0] exp_vec();
    int d;
    d = m_frz ? m_shown : m_t;
    return {to_bcd(d % 100), to_bcd((d / 100) % 60), to_bcd(d / 6000),
            1'(m_cnt || (m_frz && m_keep)), 1'(m_frz), 1'(m_wrap)};
  endfunction

  // One clock: command at negedge, model updated at posedge, sample 1 time unit later.
  task automatic step(input logic [1:0] cmd);
    @(negedge clk);
    estado = cmd;
    @(posedge clk);
    model_edge(cmd);
    #1;
  endtask

  task automatic test_reset();
    int n;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({cc, ss, mm, rodando, congelado, estouro} !== 27'd0) begin
      errs++; $display("FAIL reset_init got=%h exp=0", {cc, ss, mm, rodando, congelado, estouro});
    end
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (m_t != 347 && n < 5000) begin
      step(2'd3); n++;
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
        errs++; $display("FAIL reset_run n=%0d got=%h exp=%h", n, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
      end
    end
    vectors++;
    if ({mm, ss, cc} !== 24'h000347) begin
      errs++; $display("FAIL reset_pre got=%h exp=000347", {mm, ss, cc});
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({cc, ss, mm, rodando} !== 25'd0) begin
      errs++; $display("FAIL reset_async got=%h exp=0", {cc, ss, mm, rodando});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_count();
    step(2'd2);
    for (int i = 0; i <= 1000; i++) begin
      step(2'd3);
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
        errs++; $display("FAIL count i=%0d got=%h exp=%h", i, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
      end
      if (i == 990) begin
        vectors++;
        if ({ss, cc} !== 16'h0099) begin
          errs++; $display("FAIL count_099 got=%h exp=0099", {ss, cc});
        end
      end
    end
    vectors++;
    if ({mm, ss, cc} !== 24'h000100) begin
      errs++; $display("FAIL count_100 got=%h exp=000100", {mm, ss, cc});
    end
  endtask

  task automatic test_stop_resume();
    int n;
    step(2'd2);
    n = 0;
    while (m_t != 5 && n < 200) begin step(2'd3); n++; end
    for (int i = 0; i < 57; i++) begin
      step(2'd0);
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
        errs++; $display("FAIL stop i=%0d got=%h exp=%h", i, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
      end
    end
    vectors++;
    if (cc !== 8'h05) begin
      errs++; $display("FAIL stop_hold got=%h exp=05", cc);
    end
    // One edge advanced the prescaler to 1 before stopping: entry edge + 8 + tick = 10.
    n = 0;
    while (cc == 8'h05 && n < 40) begin
      step(2'd3); n++;
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
        errs++; $display("FAIL resume n=%0d got=%h exp=%h", n, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
      end
    end
    vectors++;
    if (n !== 10) begin
      errs++; $display("FAIL resume_latency got=%0d exp=10", n);
    end
  endtask

  task automatic test_lap();
    int n;
    step(2'd2);
    n = 0;
    while (m_t != 120 && n < 2000) begin step(2'd3); n++; end
    for (int i = 0; i < 300; i++) begin
      step(2'd1);
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
        errs++; $display("FAIL lap i=%0d got=%h exp=%h", i, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
      end
    end
    vectors++;
    if ({ss, cc, rodando, congelado} !== {16'h0120, 2'b11}) begin
      errs++; $display("FAIL lap_frozen got=%h exp=%h", {ss, cc, rodando, congelado}, {16'h0120, 2'b11});
    end
    step(2'd3);
    vectors++;
    if ({mm, ss, cc, congelado} !== {24'h000150, 1'b0}) begin
      errs++; $display("FAIL lap_release got=%h exp=%h", {mm, ss, cc, congelado}, {24'h000150, 1'b0});
    end
  endtask

  task automatic test_wrap();
    int pulses;
    step(2'd0);
    @(negedge clk);
    estado = 2'd0;
    force dut.u_cc.r_val = 8'h99;
    force dut.u_ss.r_val = 8'h59;
    force dut.u_mm.r_val = 8'h59;
    @(posedge clk);
    model_edge(2'd0);
    @(negedge clk);
    release dut.u_cc.r_val;
    release dut.u_ss.r_val;
    release dut.u_mm.r_val;
    m_t = WRAPT - 1;
    #1;
    vectors++;
    if ({mm, ss, cc} !== 24'h595999) begin
      errs++; $display("FAIL wrap_preload got=%h exp=595999", {mm, ss, cc});
    end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      step(2'd3);
      pulses += int'(estouro);
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
        errs++; $display("FAIL wrap i=%0d got=%h exp=%h", i, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
      end
    end
    vectors++;
    if (pulses !== 1) begin
      errs++; $display("FAIL wrap_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_reset_cmd_frozen();
    int n;
    step(2'd2);
    n = 0;
    while (m_t != 200 && n < 3000) begin step(2'd3); n++; end
    for (int i = 0; i < 4; i++) step(2'd1);
    vectors++;
    if (congelado !== 1'b1) begin
      errs++; $display("FAIL rstcmd_frz got=%b exp=1", congelado);
    end
    for (int i = 0; i < 5; i++) begin
      step(2'd2);
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== 27'd0) begin
        errs++; $display("FAIL rstcmd_zero i=%0d got=%h exp=0", i, {cc, ss, mm, rodando, congelado, estouro});
      end
    end
    for (int i = 0; i < 25; i++) begin
      step(2'd3);
      vectors++;
      if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
        errs++; $display("FAIL rstcmd_restart i=%0d got=%h exp=%h", i, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
      end
    end
    vectors++;
    if ({mm, ss, cc} !== 24'h000002) begin
      errs++; $display("FAIL rstcmd_count got=%h exp=000002", {mm, ss, cc});
    end
  endtask

  task automatic test_random();
    logic [1:0] cmd;
    int len;
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 9))
        0:          cmd = 2'd2;
        1, 2:       cmd = 2'd0;
        3, 4, 5:    cmd = 2'd1;
        default:    cmd = 2'd3;
      endcase
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        step(cmd);
        vectors++;
        if ({cc, ss, mm, rodando, congelado, estouro} !== exp_vec()) begin
          errs++; $display("FAIL random s=%0d i=%0d cmd=%0d got=%h exp=%h", s, i, cmd, {cc, ss, mm, rodando, congelado, estouro}, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_stop_resume();
    test_lap();
    test_wrap();
    test_reset_cmd_frozen();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
